// File: rtl/and4_sweep_pkg.sv
// Shared types and helpers for the 4-input AND/NAND sweep driver.
package and4_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned NUM_CODES = 16;

  function automatic logic expected_z(input logic [3:0] code, input logic invert);
    return (&code) ^ invert;
  endfunction

endpackage

// File: rtl/and4_sweep_checker.sv
// Compares sampled Z against the expected cell response and logs mismatches.
module and4_sweep_checker
  import and4_sweep_pkg::*;
#(
  parameter bit INVERT_CHECK = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_sample,
  input  logic [3:0] i_code,
  input  logic       i_z,
  output logic       o_mismatch,
  output logic [4:0] o_err_count,
  output logic       o_first_fail_valid,
  output logic [3:0] o_first_fail_code
);

  logic [4:0] r_err_count;
  logic       r_ff_valid;
  logic [3:0] r_ff_code;

  // Mismatch is independent of the strobe so the top can fold it into pass.
  assign o_mismatch = (i_z != expected_z(i_code, INVERT_CHECK));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count <= 5'd0;
      r_ff_valid  <= 1'b0;
      r_ff_code   <= 4'd0;
    end else if (i_clear) begin
      r_err_count <= 5'd0;
      r_ff_valid  <= 1'b0;
      r_ff_code   <= 4'd0;
    end else if (i_sample && o_mismatch) begin
      r_err_count <= r_err_count + 5'd1;
      if (!r_ff_valid) begin
        r_ff_valid <= 1'b1;
        r_ff_code  <= i_code;
      end
    end
  end

  assign o_err_count        = r_err_count;
  assign o_first_fail_valid = r_ff_valid;
  assign o_first_fail_code  = r_ff_code;

endmodule

// File: rtl/and4_sweep_driver.sv
// Drives all 16 input codes into a 4-input AND/NAND cell, samples Z after a settle
// window per code, and reports pass/fail with the first failing code.
module and4_sweep_driver
  import and4_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          INVERT_CHECK  = 1'b0
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       start,
  input  logic       abort,
  input  logic       Z,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_code
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LastCode   = 4'(NUM_CODES - 1);

  state_e     r_state, w_state_next;
  logic [3:0] r_code, w_code_next;
  logic [3:0] r_settle, w_settle_next;
  logic       r_pass, w_pass_next;
  logic       w_sample, w_clear, w_mismatch;
  logic [4:0] w_err_count;

  always_comb begin
    w_state_next  = r_state;
    w_code_next   = r_code;
    w_settle_next = r_settle;
    w_pass_next   = r_pass;
    w_sample      = 1'b0;
    w_clear       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next  = APPLY;
          w_code_next   = 4'd0;
          w_settle_next = 4'd0;
          w_pass_next   = 1'b0;
          w_clear       = 1'b1;
        end
      end
      APPLY: begin
        // Abort wins over a sample landing on the same edge.
        if (abort) begin
          w_state_next  = IDLE;
          w_code_next   = 4'd0;
          w_settle_next = 4'd0;
        end else if (r_settle == SettleLast) begin
          w_sample      = 1'b1;
          w_settle_next = 4'd0;
          w_code_next   = r_code + 4'd1;
          if (r_code == LastCode) begin
            w_state_next = DONE;
            // Final sample updates err_count on this same edge, so fold it in here.
            w_pass_next  = (w_err_count == 5'd0) && !w_mismatch;
          end
        end else begin
          w_settle_next = r_settle + 4'd1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state  <= IDLE;
      r_code   <= 4'd0;
      r_settle <= 4'd0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_code   <= w_code_next;
      r_settle <= w_settle_next;
      r_pass   <= w_pass_next;
    end
  end

  and4_sweep_checker #(
    .INVERT_CHECK(INVERT_CHECK)
  ) u_checker (
    .i_clk              (CLK),
    .i_rst_n            (RN),
    .i_clear            (w_clear),
    .i_sample           (w_sample),
    .i_code             (r_code),
    .i_z                (Z),
    .o_mismatch         (w_mismatch),
    .o_err_count        (w_err_count),
    .o_first_fail_valid (first_fail_valid),
    .o_first_fail_code  (first_fail_code)
  );

  assign A1        = r_code[0];
  assign A2        = r_code[1];
  assign A3        = r_code[2];
  assign A4        = r_code[3];
  assign busy      = (r_state == APPLY);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign err_count = w_err_count;

endmodule

// File: tb/tb_and4_sweep_driver.sv
// Scoreboard bench: stimulus queues expected sweep results, monitors check them on done.
module tb_and4_sweep_driver;

  typedef struct {
    logic        pass;
    logic [4:0]  err;
    logic        ffv;
    logic [3:0]  ffc;
    int unsigned done_cyc;
  } exp_t;

  localparam int unsigned S0 = 2;
  localparam int unsigned S1 = 0;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic z0, z1;
  logic a1_0, a2_0, a3_0, a4_0, busy0, done0, pass0, ffv0;
  logic a1_1, a2_1, a3_1, a4_1, busy1, done1, pass1, ffv1;
  logic [4:0] err0, err1;
  logic [3:0] ffc0, ffc1;
  logic [3:0] code0, code1;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  int mode0 = 0;
  int mode1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign code0 = {a4_0, a3_0, a2_0, a1_0};
  assign code1 = {a4_1, a3_1, a2_1, a1_1};

  // Cell models: 0 good AND, 1 stuck-at-0, 2 stuck-at-1, 3 wrong only on code 5.
  always_comb begin
    case (mode0)
      1:       z0 = 1'b0;
      2:       z0 = 1'b1;
      3:       z0 = (&code0) ^ (code0 == 4'd5);
      default: z0 = &code0;
    endcase
  end

  // 0 good NAND, 1 AND cell wired where a NAND is expected.
  assign z1 = (mode1 == 1) ? (&code1) : ~(&code1);

  and4_sweep_driver #(
    .SETTLE_CYCLES (S0),
    .INVERT_CHECK  (1'b0)
  ) u_dut0 (
    .CLK              (clk),
    .RN               (rn),
    .start            (start0),
    .abort            (abort0),
    .Z                (z0),
    .A1               (a1_0),
    .A2               (a2_0),
    .A3               (a3_0),
    .A4               (a4_0),
    .busy             (busy0),
    .done             (done0),
    .pass             (pass0),
    .err_count        (err0),
    .first_fail_valid (ffv0),
    .first_fail_code  (ffc0)
  );

  and4_sweep_driver #(
    .SETTLE_CYCLES (S1),
    .INVERT_CHECK  (1'b1)
  ) u_dut1 (
    .CLK              (clk),
    .RN               (rn),
    .start            (start1),
    .abort            (abort1),
    .Z                (z1),
    .A1               (a1_1),
    .A2               (a2_1),
    .A3               (a3_1),
    .A4               (a4_1),
    .busy             (busy1),
    .done             (done1),
    .pass             (pass1),
    .err_count        (err1),
    .first_fail_valid (ffv1),
    .first_fail_code  (ffc1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [4:0] e, input logic v,
                              input logic [3:0] c);
    exp_t r;
    r.pass     = p;
    r.err      = e;
    r.ffv      = v;
    r.ffc      = c;
    r.done_cyc = 0;
    return r;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("dut0_done_cycle", cyc, e.done_cyc);
        chk("dut0_pass", pass0, e.pass);
        chk("dut0_err_count", err0, e.err);
        chk("dut0_ff_valid", ffv0, e.ffv);
        chk("dut0_ff_code", ffc0, e.ffc);
        chk("dut0_code_at_done", code0, 0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("dut1_done_cycle", cyc, e.done_cyc);
        chk("dut1_pass", pass1, e.pass);
        chk("dut1_err_count", err1, e.err);
        chk("dut1_ff_valid", ffv1, e.ffv);
        chk("dut1_ff_code", ffc1, e.ffc);
      end
    end
  end

  // Issues a start pulse and queues the expected result; returns at the negedge after the start edge.
  task automatic run_start(input int dut, input exp_t e);
    @(negedge clk);
    if (dut == 0) begin
      e.done_cyc = cyc + 1 + 16 * (S0 + 1);
      q0.push_back(e);
      start0 = 1'b1;
    end else begin
      e.done_cyc = cyc + 1 + 16 * (S1 + 1);
      q1.push_back(e);
      start1 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_after_start", (dut == 0) ? busy0 : busy1, 1);
  endtask

  // Counts busy cycles (including the one seen by run_start) until busy drops.
  task automatic wait_idle(input int dut, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (((dut == 0) ? busy0 : busy1) == 1'b0) begin
        n = i + 1;
        repeat (2) @(negedge clk);
        return;
      end
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_cyc(input int unsigned target);
    for (int i = 0; i < 400; i++) begin
      if (cyc == target) return;
      @(negedge clk);
    end
    chk("wait_cycle_timeout", cyc, target);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"}, code0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_ffv"}, ffv0, 0);
    chk({tag, "_ffc"}, ffc0, 0);
  endtask

  initial begin
    int n;
    int unsigned st;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_dut1_busy", busy1, 0);
    rn = 1'b1;
    @(negedge clk);

    mode0 = 1;
    run_start(0, mk(1'b0, 5'd1, 1'b1, 4'hF));
    wait_idle(0, n);

    mode0 = 2;
    run_start(0, mk(1'b0, 5'd15, 1'b1, 4'h0));
    wait_idle(0, n);

    mode0 = 0;
    run_start(0, mk(1'b1, 5'd0, 1'b0, 4'h0));
    wait_idle(0, n);
    chk("good_busy_cycles", n, 48);
    chk("good_pass_held", pass0, 1);

    mode1 = 0;
    run_start(1, mk(1'b1, 5'd0, 1'b0, 4'h0));
    wait_idle(1, n);
    chk("nand_busy_cycles", n, 16);

    mode1 = 1;
    run_start(1, mk(1'b0, 5'd16, 1'b1, 4'h0));
    wait_idle(1, n);

    // Abort on the sample edge of code 5, where the only fault lives.
    mode0 = 3;
    @(negedge clk);
    st = cyc;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cyc(st + 18);
    chk("abort_code_before", code0, 5);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk_all_zero("abort");
    repeat (5) @(negedge clk);
    chk("abort_no_restart", busy0, 0);

    // Start re-pulsed mid-sweep must not restart; RN at code 9 clears everything at once.
    mode0 = 0;
    @(negedge clk);
    st = cyc;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cyc(st + 10);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cyc(st + 28);
    chk("repulse_code9", code0, 9);
    chk("repulse_busy", busy0, 1);
    #1 rn = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rn = 1'b1;
    run_start(0, mk(1'b1, 5'd0, 1'b0, 4'h0));
    wait_idle(0, n);
    chk("fresh_busy_cycles", n, 48);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/and4_sweep_driver.md
Name: and4_sweep_driver

Overview:
- Self-contained stimulus/check engine that drives the four inputs of a 4-input AND (or NAND) cell and samples its Z output.
- Covers all 16 input combinations exhaustively, then reports pass/fail.
- Sits beside the cell instance in silicon-bring-up and library-characterization harnesses: this block is the driving end, and the cell is the receiving end.

Parameters:
- SETTLE_CYCLES, 2, cycles inputs are held before Z is sampled; legal range 0..15.
- INVERT_CHECK, 0, 0 expects Z = A1&A2&A3&A4; 1 expects the inverted value (NAND variant).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RN  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; honoured only when busy=0.
- abort  input  1  cancel a sweep in progress.
- Z  input  1  output of the cell under exercise.
- A1  output  1  cell input, code bit 0.
- A2  output  1  cell input, code bit 1.
- A3  output  1  cell input, code bit 2.
- A4  output  1  cell input, code bit 3.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  last completed sweep had zero mismatches; held until the next start.
- err_count  output  5  mismatches in the current or last sweep, 0..16.
- first_fail_valid  output  1  at least one mismatch recorded.
- first_fail_code  output  4  code {A4,A3,A2,A1} of the first mismatch.

Behaviour:
- Reset (RN low, asynchronous): state IDLE, all outputs 0, code counter 0, settle counter 0.
- A1..A4 are registered outputs and are glitch-free.
- States: IDLE, APPLY, DONE.
- IDLE -> APPLY:
  - Taken on the edge where start=1.
  - Code=0 is driven; busy=1.
  - err_count, first_fail_valid, first_fail_code and pass are cleared.
- APPLY:
  - Holds the current code for exactly SETTLE_CYCLES+1 cycles.
  - On the final edge of that window, Z is compared against the expected value: &code, or its inverse when INVERT_CHECK=1.
  - On mismatch: err_count increments. If first_fail_valid=0, first_fail_code is set to the code and first_fail_valid is set to 1.
- Code advance:
  - On that same edge the code advances by 1. With SETTLE_CYCLES=0 a new code is therefore driven every cycle.
  - After code 15 is sampled, the next state is DONE. The code wraps to 0 and A1..A4 are driven 0.
- DONE (one cycle): done=1, busy=0, pass = (err_count==0). Next state IDLE.
- Total latency: from the start edge to the done-high cycle is 16*(SETTLE_CYCLES+1) cycles.
- start while busy: ignored, with no restart.
- start in the DONE cycle: ignored. start is accepted from IDLE only.
- abort:
  - In APPLY, abort=1 on an edge forces IDLE.
  - A1..A4 go to 0 and busy goes to 0.
  - done is not pulsed and pass stays 0. err_count and first_fail fields keep their partial values.
  - abort has priority over the sample on the same edge; that sample is discarded.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- err_count saturates naturally at 16 (5 bits); no overflow is possible.
- Z is sampled only on the final edge of each APPLY window. Z is treated as synchronous, and no synchronizer is included.
- RN asserted mid-sweep: immediate return to the reset values.

Decomposition:
- Package and4_sweep_pkg contains:
  - state enum {IDLE, APPLY, DONE};
  - constant NUM_CODES=16;
  - function expected_z(code, invert).
- One sub-module, and4_sweep_checker, receives sample strobe, code, Z and clear. It holds err_count, first_fail_valid and first_fail_code.
- FSM, code counter and settle counter stay in the top level.

Test Plan:
- Good AND cell model, SETTLE_CYCLES=2, pulse start -> busy for 48 cycles; done pulses exactly 48 cycles after the start edge; pass=1, err_count=0, first_fail_valid=0.
- Z stuck-at-0 -> err_count=1, first_fail_code=4'hF, pass=0.
- Z stuck-at-1 -> err_count=15, first_fail_code=4'h0.
- INVERT_CHECK=1 with a good NAND model, SETTLE_CYCLES=0 -> done 16 cycles after start, pass=1. The same bench with an AND model -> err_count=16.
- Fault on code 5 only; abort asserted on the sample edge of code 5 -> IDLE; A1..A4=0; no done pulse; err_count=0, first_fail_valid=0, pass=0.
- Start re-pulsed mid-sweep, then RN pulsed low at code 9 -> the re-pulse has no effect on the sequence. After RN, all outputs are 0 immediately, asynchronously. A fresh start then runs a complete sweep from code 0.
